// File: rtl/apple1_pkg.sv
// rtl/apple1_pkg.sv - shared constants and types for the Apple-1 bus controller
// Contents: FSM state encoding, default region base/mask/wait tables,
//           read value returned on a decode miss, region index type.
package apple1_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    // Region 0 = PIA keyboard pair D010/D011, region 1 = PIA display pair
    // D012/D013, region 2 = catch-all RAM (mask 0 matches everything).
    localparam logic [47:0] DEF_REGION_BASE = {16'h0000, 16'hD012, 16'hD010};
    localparam logic [47:0] DEF_REGION_MASK = {16'h0000, 16'hFFFE, 16'hFFFE};
    localparam logic [11:0] DEF_REGION_WAIT = 12'h000;

    localparam logic [7:0] MISS_DATA = 8'hFF;

    // Up to eight regions, so a 3-bit index always suffices.
    typedef logic [2:0] region_idx_t;

endpackage

// File: rtl/apple1_addr_decode.sv
// rtl/apple1_addr_decode.sv - combinational priority address decode
// Ports: addr (CPU address) -> hit_vec (one-hot region), hit_idx (region
//        index), hit (any region matched). Lowest region index wins.
module apple1_addr_decode
    import apple1_pkg::*;
#(
    parameter int                      N_REGIONS   = 3,
    parameter logic [16*N_REGIONS-1:0] REGION_BASE = DEF_REGION_BASE,
    parameter logic [16*N_REGIONS-1:0] REGION_MASK = DEF_REGION_MASK
) (
    input  logic [15:0]          addr,
    output logic [N_REGIONS-1:0] hit_vec,
    output region_idx_t          hit_idx,
    output logic                 hit
);

    // Scan from the highest index down so the lowest matching region is
    // the last one written and therefore takes priority.
    always_comb begin
        hit_vec = '0;
        hit_idx = '0;
        hit     = 1'b0;
        for (int k = N_REGIONS - 1; k >= 0; k--) begin
            if ((addr & REGION_MASK[16*k +: 16]) ==
                (REGION_BASE[16*k +: 16] & REGION_MASK[16*k +: 16])) begin
                hit_vec    = '0;
                hit_vec[k] = 1'b1;
                hit_idx    = region_idx_t'(k);
                hit        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apple1_bus_ctrl.sv
// rtl/apple1_bus_ctrl.sv - Apple-1 bus controller: region decode, wait states, write strobes
// Ports: sys_clock/reset (sync, active high); cpu_clken, cpu_addr, cpu_we in;
//        cpu_din, cpu_ready out; sl_dout, sl_wait in per region; sl_cs, sl_wr
//        out per region; bus_err out only when APPLE1_BUS_TIMEOUT_EN is defined.
// Macro: APPLE1_BUS_TIMEOUT_EN adds a per-access stall counter that aborts
//        an access after TIMEOUT ready-low strobes and sets sticky bus_err.
module apple1_bus_ctrl
    import apple1_pkg::*;
#(
    parameter int                      N_REGIONS   = 3,
    parameter logic [16*N_REGIONS-1:0] REGION_BASE = DEF_REGION_BASE,
    parameter logic [16*N_REGIONS-1:0] REGION_MASK = DEF_REGION_MASK,
    parameter logic [4*N_REGIONS-1:0]  REGION_WAIT = '0,
    parameter int                      TIMEOUT     = 255
) (
    input  logic                   sys_clock,
    input  logic                   reset,
    input  logic                   cpu_clken,
    input  logic [15:0]            cpu_addr,
    input  logic                   cpu_we,
    output logic [7:0]             cpu_din,
    output logic                   cpu_ready,
    input  logic [8*N_REGIONS-1:0] sl_dout,
    input  logic [N_REGIONS-1:0]   sl_wait,
    output logic [N_REGIONS-1:0]   sl_cs,
    output logic [N_REGIONS-1:0]   sl_wr
`ifdef APPLE1_BUS_TIMEOUT_EN
    ,
    output logic                   bus_err
`endif
);

    logic [0:0]           state;
    region_idx_t          lat_idx;
    logic [3:0]           cnt;

    logic [N_REGIONS-1:0] dec_vec;
    region_idx_t          dec_idx;
    logic                 dec_hit;

    region_idx_t          sel_idx;
    logic                 sel_hit;
    logic [3:0]           sel_w;
    logic                 sel_busy;
    logic                 ready_raw;
    logic                 timed_out;
    logic [7:0]           lat_vec8;

    // Per-region tables padded to 8 entries so a 3-bit index never runs
    // past the end; unused entries look like an idle, zero-wait miss.
    logic [3:0]           wait_tab [8];
    logic [7:0]           dout_tab [8];
    logic [7:0]           busy_tab;

    apple1_addr_decode #(
        .N_REGIONS   (N_REGIONS),
        .REGION_BASE (REGION_BASE),
        .REGION_MASK (REGION_MASK)
    ) u_decode (
        .addr    (cpu_addr),
        .hit_vec (dec_vec),
        .hit_idx (dec_idx),
        .hit     (dec_hit)
    );

    always_comb begin
        busy_tab = '0;
        for (int k = 0; k < 8; k++) begin
            wait_tab[k] = '0;
            dout_tab[k] = MISS_DATA;
        end
        for (int k = 0; k < N_REGIONS; k++) begin
            wait_tab[k] = REGION_WAIT[4*k +: 4];
            dout_tab[k] = sl_dout[8*k +: 8];
            busy_tab[k] = sl_wait[k];
        end
    end

    // In WAIT the region latched on entry is authoritative; the CPU may
    // already be driving the next address.
    assign sel_idx  = (state == ST_WAIT) ? lat_idx : dec_idx;
    assign sel_hit  = (state == ST_WAIT) || dec_hit;
    assign sel_w    = wait_tab[sel_idx];
    assign sel_busy = busy_tab[sel_idx];
    assign lat_vec8 = 8'b1 << lat_idx;
    assign sl_cs    = (state == ST_WAIT) ? lat_vec8[N_REGIONS-1:0] : dec_vec;

    always_comb begin
        ready_raw = 1'b1;
        if (sel_hit) begin
            if (state == ST_IDLE) begin
                ready_raw = (sel_w == 4'd0) && !sel_busy;
            end else begin
                ready_raw = (cnt == 4'd0) && !sel_busy;
            end
        end
    end

    assign cpu_ready = ready_raw | timed_out;
    assign cpu_din   = (!sel_hit || timed_out) ? MISS_DATA : dout_tab[sel_idx];
    // Ready is high on exactly one strobe per access, so this is one pulse.
    assign sl_wr     = sl_cs & {N_REGIONS{cpu_we & cpu_ready & cpu_clken & !timed_out}};

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            lat_idx <= '0;
        end else if (cpu_clken) begin
            if (state == ST_IDLE) begin
                // Ready low in IDLE implies a hit, so dec_idx is valid here.
                if (!cpu_ready) begin
                    lat_idx <= dec_idx;
                    cnt     <= (sel_w == 4'd0) ? 4'd0 : sel_w - 4'd1;
                    state   <= ST_WAIT;
                end
            end else begin
                if (timed_out) begin
                    cnt   <= '0;
                    state <= ST_IDLE;
                end else if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end else if (!sel_busy) begin
                    state <= ST_IDLE;
                end
            end
        end
    end

`ifdef APPLE1_BUS_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    logic [7:0] stall_cnt;
    logic [7:0] stall_next;

    assign stall_next = stall_cnt + 8'd1;
    assign timed_out  = (state == ST_WAIT) && (stall_cnt == TIMEOUT_CNT);

    // Every ready-low strobe of an access counts; any ready-high strobe
    // (normal completion or forced abort) ends the access and clears it.
    always_ff @(posedge sys_clock) begin
        if (reset) begin
            stall_cnt <= '0;
            bus_err   <= 1'b0;
        end else if (cpu_clken) begin
            if (!cpu_ready) begin
                stall_cnt <= stall_next;
                if (stall_next == TIMEOUT_CNT) begin
                    bus_err <= 1'b1;
                end
            end else begin
                stall_cnt <= '0;
            end
        end
    end
`else
    logic unused_timeout;

    assign timed_out      = 1'b0;
    assign unused_timeout = ^TIMEOUT;
`endif

endmodule

// File: tb/tb_apple1_bus_ctrl.sv
// tb/tb_apple1_bus_ctrl.sv - directed self-checking bench for apple1_bus_ctrl
module tb_apple1_bus_ctrl;

    logic        sys_clock = 1'b0;
    logic        reset     = 1'b1;
    logic        cpu_clken = 1'b0;
    logic [15:0] cpu_addr  = 16'h0000;
    logic        cpu_we    = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 sys_clock = ~sys_clock;

    // u_a: default parameters
    logic [7:0]  din_a;
    logic        ready_a;
    logic [2:0]  cs_a, wr_a;
    logic [2:0]  wait_a = 3'b000;
    logic [23:0] dout_a = {8'h33, 8'h22, 8'h11};
    // u_b: wait states {3,2,0}, timeout 4
    logic [7:0]  din_b;
    logic        ready_b;
    logic [2:0]  cs_b, wr_b;
    logic [2:0]  wait_b = 3'b000;
    logic [23:0] dout_b = {8'hC3, 8'hB2, 8'hA1};
    // u_c: one region, mask 0
    logic [7:0]  din_c;
    logic        ready_c;
    logic [0:0]  cs_c, wr_c;
    logic [0:0]  wait_c = 1'b0;
    logic [7:0]  dout_c = 8'h5A;
    // u_d: two overlapping regions
    logic [7:0]  din_d;
    logic        ready_d;
    logic [1:0]  cs_d, wr_d;
    logic [1:0]  wait_d = 2'b00;
    logic [15:0] dout_d = {8'h77, 8'h66};
`ifdef APPLE1_BUS_TIMEOUT_EN
    logic err_a, err_b, err_c, err_d;
`endif

    apple1_bus_ctrl u_a (
        .sys_clock(sys_clock), .reset(reset), .cpu_clken(cpu_clken),
        .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_din(din_a), .cpu_ready(ready_a),
        .sl_dout(dout_a), .sl_wait(wait_a), .sl_cs(cs_a), .sl_wr(wr_a)
`ifdef APPLE1_BUS_TIMEOUT_EN
        , .bus_err(err_a)
`endif
    );

    apple1_bus_ctrl #(.REGION_WAIT(12'h320), .TIMEOUT(4)) u_b (
        .sys_clock(sys_clock), .reset(reset), .cpu_clken(cpu_clken),
        .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_din(din_b), .cpu_ready(ready_b),
        .sl_dout(dout_b), .sl_wait(wait_b), .sl_cs(cs_b), .sl_wr(wr_b)
`ifdef APPLE1_BUS_TIMEOUT_EN
        , .bus_err(err_b)
`endif
    );

    apple1_bus_ctrl #(.N_REGIONS(1), .REGION_BASE(16'h0000), .REGION_MASK(16'h0000),
                      .REGION_WAIT(4'h0)) u_c (
        .sys_clock(sys_clock), .reset(reset), .cpu_clken(cpu_clken),
        .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_din(din_c), .cpu_ready(ready_c),
        .sl_dout(dout_c), .sl_wait(wait_c), .sl_cs(cs_c), .sl_wr(wr_c)
`ifdef APPLE1_BUS_TIMEOUT_EN
        , .bus_err(err_c)
`endif
    );

    apple1_bus_ctrl #(.N_REGIONS(2), .REGION_BASE({16'hD000, 16'hD010}),
                      .REGION_MASK({16'hFF00, 16'hFFFE}), .REGION_WAIT(8'h00)) u_d (
        .sys_clock(sys_clock), .reset(reset), .cpu_clken(cpu_clken),
        .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_din(din_d), .cpu_ready(ready_d),
        .sl_dout(dout_d), .sl_wait(wait_d), .sl_cs(cs_d), .sl_wr(wr_d)
`ifdef APPLE1_BUS_TIMEOUT_EN
        , .bus_err(err_d)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        // Reset state: IDLE, decode visible, no strobes
        cpu_addr = 16'hD010;
        step();
        step();
        reset = 1'b0;
        #1;
        check("rst_ready_a", ready_a, 1);
        check("rst_cs_a", cs_a, 3'b001);
        check("rst_wr_a", wr_a, 3'b000);
        check("rst_ready_b", ready_b, 1);

        // Default decode reads
        cpu_clken = 1'b1;
        cpu_addr  = 16'hD011;
        #1;
        check("rd_d011_cs", cs_a, 3'b001);
        check("rd_d011_ready", ready_a, 1);
        check("rd_d011_din", din_a, 8'h11);
        cpu_addr = 16'h1234;
        #1;
        check("rd_1234_cs", cs_a, 3'b100);
        check("rd_1234_din", din_a, 8'h33);
        cpu_addr = 16'hD013;
        #1;
        check("rd_d013_cs", cs_a, 3'b010);
        check("rd_d013_din", din_a, 8'h22);

        // Zero-wait write: strobe only while cpu_clken is high
        cpu_addr = 16'hD012;
        cpu_we   = 1'b1;
        #1;
        check("wr0_pulse", wr_a, 3'b010);
        cpu_clken = 1'b0;
        #1;
        check("wr0_noclken", wr_a, 3'b000);
        cpu_we = 1'b0;

        // Three wait states on RAM, address change ignored, clken gaps
        do_reset();
        cpu_clken = 1'b1;
        cpu_addr  = 16'h0200;
        #1;
        check("w3_s0_ready", ready_b, 0);
        check("w3_s0_cs", cs_b, 3'b100);
        step();
        cpu_addr = 16'hD010;
        #1;
        check("w3_s1_ready", ready_b, 0);
        check("w3_s1_cs_held", cs_b, 3'b100);
        step();
        cpu_clken = 1'b0;
        step();
        step();
        check("w3_gap_ready", ready_b, 0);
        cpu_clken = 1'b1;
        #1;
        check("w3_s2_ready", ready_b, 0);
        step();
        check("w3_done_ready", ready_b, 1);
        check("w3_done_din", din_b, 8'hC3);
        check("w3_done_cs", cs_b, 3'b100);
        step();
        check("w3_idle_cs", cs_b, 3'b001);
        check("w3_idle_ready", ready_b, 1);

        // Two-wait write: one pulse on the completing strobe only
        do_reset();
        cpu_addr = 16'hD012;
        cpu_we   = 1'b1;
        #1;
        check("w2_s0_wr", wr_b, 3'b000);
        check("w2_s0_ready", ready_b, 0);
        step();
        check("w2_s1_wr", wr_b, 3'b000);
        step();
        check("w2_s2_ready", ready_b, 1);
        check("w2_s2_wr", wr_b, 3'b010);
        step();
        check("w2_after_wr", wr_b, 3'b000);

        // Reset in the middle of a wait sequence
        do_reset();
        cpu_addr = 16'h0200;
        #1;
        step();
        check("rw_wait_ready", ready_b, 0);
        reset = 1'b1;
        #1;
        check("rw_rst_wr", wr_b, 3'b000);
        step();
        reset    = 1'b0;
        cpu_we   = 1'b0;
        cpu_addr = 16'hD010;
        #1;
        check("rw_after_cs", cs_b, 3'b001);
        check("rw_after_ready", ready_b, 1);

        // External wait held high on region 0
        do_reset();
        cpu_addr = 16'hD010;
        cpu_we   = 1'b1;
        wait_b   = 3'b001;
        #1;
`ifdef APPLE1_BUS_TIMEOUT_EN
        check("to_err_start", err_b, 0);
        for (int i = 0; i < 4; i++) begin
            check("to_stall_ready", ready_b, 0);
            check("to_stall_wr", wr_b, 3'b000);
            step();
        end
        check("to_ready", ready_b, 1);
        check("to_din", din_b, 8'hFF);
        check("to_wr", wr_b, 3'b000);
        check("to_err", err_b, 1);
        wait_b = 3'b000;
        step();
        step();
        check("to_err_sticky", err_b, 1);
        do_reset();
        check("to_err_rst", err_b, 0);
`else
        for (int i = 0; i < 12; i++) begin
            check("st_stall_ready", ready_b, 0);
            check("st_stall_wr", wr_b, 3'b000);
            step();
        end
        wait_b = 3'b000;
        #1;
        check("st_rel_ready", ready_b, 1);
        check("st_rel_din", din_b, 8'hA1);
        check("st_rel_wr", wr_b, 3'b001);
        step();
`endif
        cpu_we = 1'b0;
        wait_b = 3'b000;

        // Overlapping regions, miss, single catch-all region
        cpu_addr = 16'hD010;
        #1;
        check("ov_d010_cs", cs_d, 2'b01);
        check("ov_d010_din", din_d, 8'h66);
        cpu_addr = 16'hD020;
        #1;
        check("ov_d020_cs", cs_d, 2'b10);
        check("ov_d020_din", din_d, 8'h77);
        cpu_addr = 16'h1234;
        #1;
        check("miss_cs", cs_d, 2'b00);
        check("miss_ready", ready_d, 1);
        check("miss_din", din_d, 8'hFF);
        check("one_1234_cs", cs_c, 1'b1);
        check("one_1234_din", din_c, 8'h5A);
        cpu_addr = 16'hFFFF;
        #1;
        check("one_ffff_cs", cs_c, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apple1_bus_ctrl.md
APPLE1_BUS_CTRL -- requirements
Module: apple1_bus_ctrl

Interface
REQ-001 SHALL have parameter N_REGIONS, default 3: number of decoded regions, range 1..8.
REQ-002 SHALL have parameter REGION_BASE (16*N_REGIONS bits), default {16'h0000,16'hD012,16'hD010}: region k base address in bits [16k+15:16k].
REQ-003 SHALL have parameter REGION_MASK (16*N_REGIONS bits), default {16'h0000,16'hFFFE,16'hFFFE}: compare mask per region.
REQ-004 SHALL have parameter REGION_WAIT (4*N_REGIONS bits), default all 0: fixed wait strobes per region.
REQ-005 SHALL have parameter TIMEOUT, default 255: maximum stall strobes, range 1..255.
REQ-006 sys_clock  in  1  system clock, sole clock.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 cpu_clken  in  1  CPU clock enable; one strobe = one CPU bus cycle.
REQ-009 cpu_addr  in  16  CPU address.
REQ-010 cpu_we  in  1  CPU write request.
REQ-011 cpu_din  out  8  read data to CPU.
REQ-012 cpu_ready  out  1  CPU ready; low stalls the CPU.
REQ-013 sl_dout  in  8*N_REGIONS  region k read data in bits [8k+7:8k].
REQ-014 sl_wait  in  N_REGIONS  per-region external wait request, active high.
REQ-015 sl_cs  out  N_REGIONS  one-hot region select.
REQ-016 sl_wr  out  N_REGIONS  one-strobe write pulse per region.
REQ-017 bus_err  out  1  sticky timeout flag; exists only with the macro defined.

Function
REQ-018 Region k SHALL hit when (cpu_addr & MASK[k]) == (BASE[k] & MASK[k]); the lowest index wins; no hit selects no region.
REQ-019 In IDLE, sl_cs SHALL follow the combinational decode; in WAIT, sl_cs SHALL hold the region latched on entry and ignore cpu_addr changes.
REQ-020 FSM states SHALL be IDLE and WAIT only.
REQ-021 cpu_ready SHALL be 1 in IDLE when hit region W==0 and sl_wait[k]==0, or on a miss; 1 in WAIT when cnt==0 and sl_wait[k]==0; 0 otherwise.
REQ-022 IDLE with cpu_clken and cpu_ready==0: latch region index, load cnt = W-1 (saturate at 0 when W==0), go to WAIT.
REQ-023 WAIT with cpu_clken: if cnt!=0, decrement; else if sl_wait[k]==0, go to IDLE; else hold.
REQ-024 An access to a region with W wait states and sl_wait low SHALL hold cpu_ready low for exactly W cpu_clken strobes.
REQ-025 cpu_din SHALL be sl_dout of the selected region, or 8'hFF on a miss; the mux SHALL be combinational.
REQ-026 sl_wr[k] SHALL equal cpu_we & sl_cs[k] & cpu_ready & cpu_clken, giving exactly one pulse per write access.
REQ-027 Without cpu_clken, the state, counters and strobes SHALL not advance.

Reset
REQ-028 On reset, state SHALL be IDLE, cnt 0, latched region 0, stall counter 0, and bus_err 0.
REQ-029 Reset during WAIT SHALL abort the access with no sl_wr pulse, and cpu_ready SHALL follow REQ-021 on the next cycle.

Configuration
REQ-030 With APPLE1_BUS_TIMEOUT_EN defined, a stall counter SHALL count ready-low strobes per access.
REQ-031 When the stall counter reaches TIMEOUT, the block SHALL force cpu_ready=1, force cpu_din=8'hFF, suppress sl_wr, set bus_err, and return to IDLE.
REQ-032 bus_err SHALL clear only on reset.
REQ-033 Without the macro, there SHALL be no stall counter and no bus_err port, and sl_wait SHALL stall indefinitely.

Structure
REQ-034 The package apple1_pkg SHALL hold the state encoding, the default base/mask/wait constants and the 8'hFF miss value.
REQ-035 One sub-module, apple1_addr_decode, SHALL provide the combinational priority decode to a one-hot vector plus index.
REQ-036 Target size: 120-400 RTL lines.

Verification
REQ-037 Defaults; read 0xD011 -> sl_cs=3'b001, cpu_ready=1, cpu_din=sl_dout[7:0]; read 0x1234 -> sl_cs=3'b100.
REQ-038 REGION_WAIT[2]=3; read 0x0200 -> cpu_ready low for exactly 3 strobes, then high with RAM data.
REQ-039 Write 0xD012 with W=2 -> a single sl_wr[1] pulse on the completing strobe only.
REQ-040 Macro on, TIMEOUT=4, sl_wait[0] held high -> ready low 4 strobes, then cpu_din=8'hFF, bus_err=1, no sl_wr.
REQ-041 Reset asserted mid-WAIT -> next cycle IDLE, cpu_ready per decode, no sl_wr.
REQ-042 Overlapping regions 0 and 1 both hit 0xD010 -> sl_cs=one-hot bit 0; N_REGIONS=1 with mask 0 -> every address hits.
